// File: rtl/load_store_unit.sv
// MEM-stage load/store initiator: byte-addressed requests to word-indexed memory strobes.
// Optional read-modify-write of unaligned sub-word stores is enabled by defining LSU_RMW_EN.
module load_store_unit #(
   parameter int DEPTH = 32
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_valid,
   output logic        o_ready,
   input  logic        i_load,
   input  logic        i_store,
   input  logic [31:0] i_addr,
   input  logic [31:0] i_wdata,
   input  logic [1:0]  i_size,
   input  logic        i_sign,
   output logic        o_done,
   output logic        o_fault,
   output logic [31:0] o_rdata,
   output logic [31:0] o_mem_addr,
   output logic [31:0] o_mem_wdata,
   output logic        o_mem_write,
   output logic        o_mem_read,
   output logic [1:0]  o_mem_long,
   output logic        o_mem_sign,
   input  logic [31:0] i_mem_rdata
);

   localparam logic [1:0]  SZ_BYTE = 2'b00;
   localparam logic [1:0]  SZ_HALF = 2'b01;
   localparam logic [1:0]  SZ_WORD = 2'b11;
   localparam logic [31:0] DEPTH_W = 32'(DEPTH);

   typedef enum logic [2:0] {
      IDLE,
      RD_REQ,
      RD_WAIT,
      WR,
      RESP
   } state_t;

   state_t      state;
   logic [1:0]  off_q;
   logic [1:0]  size_q;
   logic        sign_q;
   logic        needs_rmw;
   logic        req_fault;
   logic [31:0] load_ext;

`ifdef LSU_RMW_EN
   logic        rmw_q;
   logic [31:0] wdata_q;
   logic [31:0] merge;
`endif

   // Extension is done locally, so the memory is always asked for raw data.
   assign o_mem_sign = 1'b0;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      needs_rmw = 1'b0;
      if (i_store && !i_load) begin
         if (i_size == SZ_BYTE && i_addr[1:0] != 2'b00) needs_rmw = 1'b1;
         if (i_size == SZ_HALF && i_addr[1:0] == 2'b10) needs_rmw = 1'b1;
      end
   end

   always_comb begin
      req_fault = 1'b0;
      if (i_load == i_store)                              req_fault = 1'b1;
      if (i_size == 2'b10)                                req_fault = 1'b1;
      if (i_size == SZ_HALF && i_addr[0])                 req_fault = 1'b1;
      if (i_size == SZ_WORD && i_addr[1:0] != 2'b00)      req_fault = 1'b1;
      if ({2'b00, i_addr[31:2]} >= DEPTH_W)               req_fault = 1'b1;
`ifndef LSU_RMW_EN
      if (needs_rmw)                                      req_fault = 1'b1;
`endif
   end

   // Lane extraction from the word returned by memory during RD_WAIT.
   always_comb begin
      load_ext = i_mem_rdata;
      case (size_q)
         SZ_BYTE: begin
            load_ext[7:0]  = i_mem_rdata[{off_q, 3'b000} +: 8];
            load_ext[31:8] = {24{sign_q & load_ext[7]}};
         end
         SZ_HALF: begin
            load_ext[15:0]  = i_mem_rdata[{off_q[1], 4'b0000} +: 16];
            load_ext[31:16] = {16{sign_q & load_ext[15]}};
         end
         default: load_ext = i_mem_rdata;
      endcase
   end

`ifdef LSU_RMW_EN
   always_comb begin
      merge = i_mem_rdata;
      if (size_q == SZ_HALF) merge[{off_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      else                   merge[{off_q, 3'b000} +: 8]      = wdata_q[7:0];
   end
`endif

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state       <= IDLE;
         o_ready     <= 1'b1;
         o_done      <= 1'b0;
         o_fault     <= 1'b0;
         o_rdata     <= '0;
         o_mem_addr  <= '0;
         o_mem_wdata <= '0;
         o_mem_write <= 1'b0;
         o_mem_read  <= 1'b0;
         o_mem_long  <= '0;
         off_q       <= '0;
         size_q      <= '0;
         sign_q      <= 1'b0;
`ifdef LSU_RMW_EN
         rmw_q       <= 1'b0;
         wdata_q     <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (i_valid) begin
                  o_ready <= 1'b0;
                  off_q   <= i_addr[1:0];
                  size_q  <= i_size;
                  sign_q  <= i_sign;
`ifdef LSU_RMW_EN
                  rmw_q   <= needs_rmw;
                  wdata_q <= i_wdata;
`endif
                  if (req_fault) begin
                     o_done  <= 1'b1;
                     o_fault <= 1'b1;
                     state   <= RESP;
                  end else begin
                     o_mem_addr <= {2'b00, i_addr[31:2]};
                     if (i_load || needs_rmw) begin
                        o_mem_read <= 1'b1;
                        o_mem_long <= SZ_WORD;
                        state      <= RD_REQ;
                     end else begin
                        o_mem_write <= 1'b1;
                        o_mem_long  <= i_size;
                        o_mem_wdata <= i_wdata;
                        state       <= WR;
                     end
                  end
               end
            end
            RD_REQ: begin
               o_mem_read <= 1'b0;
               state      <= RD_WAIT;
            end
            RD_WAIT: begin
`ifdef LSU_RMW_EN
               if (rmw_q) begin
                  // o_mem_wdata doubles as the merge register for the write phase.
                  o_mem_wdata <= merge;
                  o_mem_long  <= SZ_WORD;
                  o_mem_write <= 1'b1;
                  state       <= WR;
               end else begin
                  o_rdata <= load_ext;
                  o_done  <= 1'b1;
                  state   <= RESP;
               end
`else
               o_rdata <= load_ext;
               o_done  <= 1'b1;
               state   <= RESP;
`endif
            end
            WR: begin
               o_mem_write <= 1'b0;
               o_done      <= 1'b1;
               state       <= RESP;
            end
            RESP: begin
               o_done  <= 1'b0;
               o_fault <= 1'b0;
               o_ready <= 1'b1;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: memory model, directed vector table, random
// requests scored against a byte-arithmetic reference model, and a reset-mid-access sequence.
module tb_load_store_unit;

   localparam int DEPTH = 32;
`ifdef LSU_RMW_EN
   localparam bit RMW_EN = 1'b1;
`else
   localparam bit RMW_EN = 1'b0;
`endif

   logic        i_clk = 1'b0;
   logic        i_rst = 1'b0;
   logic        i_valid = 1'b0;
   logic        o_ready;
   logic        i_load = 1'b0;
   logic        i_store = 1'b0;
   logic [31:0] i_addr = '0;
   logic [31:0] i_wdata = '0;
   logic [1:0]  i_size = '0;
   logic        i_sign = 1'b0;
   logic        o_done;
   logic        o_fault;
   logic [31:0] o_rdata;
   logic [31:0] o_mem_addr;
   logic [31:0] o_mem_wdata;
   logic        o_mem_write;
   logic        o_mem_read;
   logic [1:0]  o_mem_long;
   logic        o_mem_sign;
   logic [31:0] i_mem_rdata = '0;

   int n_checks = 0;
   int n_fail = 0;

   load_store_unit #(.DEPTH(DEPTH)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
      .i_load(i_load), .i_store(i_store), .i_addr(i_addr), .i_wdata(i_wdata),
      .i_size(i_size), .i_sign(i_sign), .o_done(o_done), .o_fault(o_fault),
      .o_rdata(o_rdata), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
      .o_mem_write(o_mem_write), .o_mem_read(o_mem_read), .o_mem_long(o_mem_long),
      .o_mem_sign(o_mem_sign), .i_mem_rdata(i_mem_rdata)
   );

   always #5 i_clk = ~i_clk;

   // Data memory: registered read, Long-sized write at byte offset 0 of the word.
   logic [31:0] dmem [DEPTH] = '{default: 32'h0};
   always @(posedge i_clk) begin
      if (o_mem_read) i_mem_rdata <= dmem[o_mem_addr % DEPTH];
      if (o_mem_write) begin
         case (o_mem_long)
            2'b00:   dmem[o_mem_addr % DEPTH][7:0]  <= o_mem_wdata[7:0];
            2'b01:   dmem[o_mem_addr % DEPTH][15:0] <= o_mem_wdata[15:0];
            default: dmem[o_mem_addr % DEPTH]       <= o_mem_wdata;
         endcase
      end
   end

   typedef struct {
      logic        fault;
      int          lat;
      int          nrd;
      int          nwr;
      logic [1:0]  wlong;
      logic [31:0] rdata;
   } exp_t;

   typedef struct {
      int          lat;
      int          nrd;
      int          nwr;
      logic [1:0]  wlong;
      logic [31:0] rd_addr;
      logic [31:0] wr_addr;
      logic        flt;
      logic [31:0] rdata;
      logic        done_after;
      logic        ready_after;
   } res_t;

   typedef struct {
      logic        ld;
      logic        st;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [1:0]  size;
      logic        sign;
      logic        exp_fault;
      int          exp_lat;
      logic [31:0] exp_rdata;
      logic [1:0]  exp_long;
      logic [31:0] exp_word;
   } vec_t;

   logic [31:0] ref_mem [DEPTH] = '{default: 32'h0};
   logic [31:0] ref_rdata = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Reference model: decides the outcome from sizes, offsets and byte arithmetic.
   task automatic model(input logic ld, input logic st, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [1:0] size, input logic sg,
                        output exp_t e);
      int           off;
      int           nbytes;
      logic [31:0]  idx;
      bit           unaligned_sub;
      longint unsigned v;
      longint unsigned lmask;
      off    = int'(addr % 4);
      idx    = addr >> 2;
      nbytes = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : (size == 2'b11) ? 4 : 0;
      unaligned_sub = st && !ld && nbytes > 0 && nbytes < 4 && off != 0;
      e.fault = (ld == st) || nbytes == 0 || (nbytes > 0 && off % nbytes != 0) ||
                idx >= DEPTH || (unaligned_sub && !RMW_EN);
      e.nrd = 0;
      e.nwr = 0;
      e.wlong = 2'b00;
      if (e.fault) begin
         e.lat = 1;
      end else if (ld) begin
         v = longint'(ref_mem[idx % DEPTH]) >> (8 * off);
         v = v & ((64'd1 << (8 * nbytes)) - 1);
         if (sg && nbytes < 4 && ((v >> (8 * nbytes - 1)) & 1) == 1)
            v = v + 64'h1_0000_0000 - (64'd1 << (8 * nbytes));
         ref_rdata = v[31:0];
         e.lat = 3;
         e.nrd = 1;
      end else begin
         lmask = ((64'd1 << (8 * nbytes)) - 1) << (8 * off);
         v = (longint'(ref_mem[idx % DEPTH]) & ~lmask) | ((longint'(wdata) << (8 * off)) & lmask);
         ref_mem[idx % DEPTH] = v[31:0];
         e.lat   = unaligned_sub ? 4 : 2;
         e.nrd   = unaligned_sub ? 1 : 0;
         e.nwr   = 1;
         e.wlong = unaligned_sub ? 2'b11 : size;
      end
      e.rdata = ref_rdata;
   endtask

   task automatic run_req(input logic ld, input logic st, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [1:0] sz, input logic sg,
                          output res_t r);
      int w;
      r.lat = -1; r.nrd = 0; r.nwr = 0; r.wlong = 2'b00; r.rd_addr = '0; r.wr_addr = '0;
      r.flt = 1'b0; r.rdata = '0; r.done_after = 1'b0; r.ready_after = 1'b1;
      @(negedge i_clk);
      i_load = ld; i_store = st; i_addr = addr; i_wdata = wd; i_size = sz; i_sign = sg;
      i_valid = 1'b1;
      w = 0;
      while (!o_ready && w < 8) begin
         @(negedge i_clk);
         w++;
      end
      if (!o_ready) begin
         check("ready_timeout", 32'(o_ready), 32'd1);
         i_valid = 1'b0;
         return;
      end
      @(posedge i_clk);
      #1 i_valid = 1'b0;
      for (int n = 1; n <= 8; n++) begin
         @(negedge i_clk);
         if (o_mem_read)  begin r.nrd++; r.rd_addr = o_mem_addr; end
         if (o_mem_write) begin r.nwr++; r.wr_addr = o_mem_addr; r.wlong = o_mem_long; end
         if (o_done) begin
            r.lat = n; r.flt = o_fault; r.rdata = o_rdata;
            break;
         end
      end
      if (r.lat != -1) begin
         @(negedge i_clk);
         r.done_after = o_done;
         r.ready_after = o_ready;
      end
   endtask

   task automatic compare(input string tag, input logic [31:0] addr, input exp_t e, input res_t r);
      logic [31:0] idx;
      idx = addr >> 2;
      check({tag, " latency"}, 32'(r.lat), 32'(e.lat));
      check({tag, " fault"}, 32'(r.flt), 32'(e.fault));
      check({tag, " reads"}, 32'(r.nrd), 32'(e.nrd));
      check({tag, " writes"}, 32'(r.nwr), 32'(e.nwr));
      check({tag, " rdata"}, r.rdata, e.rdata);
      check({tag, " done pulse"}, {30'd0, r.done_after, r.ready_after}, 32'd1);
      if (e.nrd > 0) check({tag, " read addr"}, r.rd_addr, idx);
      if (e.nwr > 0) begin
         check({tag, " write addr"}, r.wr_addr, idx);
         check({tag, " write long"}, 32'(r.wlong), 32'(e.wlong));
      end
      if (idx < DEPTH) check({tag, " mem word"}, dmem[idx % DEPTH], ref_mem[idx % DEPTH]);
   endtask

   task automatic do_checked(input string tag, input logic ld, input logic st,
                             input logic [31:0] addr, input logic [31:0] wd,
                             input logic [1:0] sz, input logic sg);
      exp_t e;
      res_t r;
      model(ld, st, addr, wd, sz, sg, e);
      run_req(ld, st, addr, wd, sz, sg, r);
      compare(tag, addr, e, r);
   endtask

   function automatic vec_t mk(logic ld, logic st, logic [31:0] addr, logic [31:0] wd,
                               logic [1:0] sz, logic sg, logic f, int lat,
                               logic [31:0] rd, logic [1:0] lg, logic [31:0] word);
      vec_t v;
      v.ld = ld; v.st = st; v.addr = addr; v.wdata = wd; v.size = sz; v.sign = sg;
      v.exp_fault = f; v.exp_lat = lat; v.exp_rdata = rd; v.exp_long = lg; v.exp_word = word;
      return v;
   endfunction

   vec_t vecs [16];
   int   n_vecs;

   initial begin
      exp_t        e;
      res_t        r;
      logic [31:0] w3_before;
      logic [31:0] word;
      int          bad;

      // Directed vectors: {ld, st, addr, wdata, size, sign, fault, latency, rdata, long, word}
      vecs[0]  = mk(1, 0, 32'h0D, 32'h0, 2'b00, 1, 0, 3, 32'hFFFFFFAA, 2'b00, 32'h0);
      vecs[1]  = mk(1, 0, 32'h0E, 32'h0, 2'b01, 0, 0, 3, 32'h00008899, 2'b00, 32'h0);
      vecs[2]  = mk(1, 0, 32'h0C, 32'h0, 2'b11, 0, 0, 3, 32'h8899AABB, 2'b00, 32'h0);
      if (RMW_EN)
         vecs[3] = mk(0, 1, 32'h0E, 32'h5C, 2'b00, 0, 0, 4, 32'h8899AABB, 2'b11, 32'h885CAABB);
      else
         vecs[3] = mk(0, 1, 32'h0E, 32'h5C, 2'b00, 0, 1, 1, 32'h8899AABB, 2'b00, 32'h8899AABB);
      vecs[4]  = mk(0, 1, 32'h0D, 32'h1234, 2'b01, 0, 1, 1, 32'h8899AABB, 2'b00, 32'h0);
      vecs[5]  = mk(1, 0, 32'h0E, 32'h0, 2'b11, 0, 1, 1, 32'h8899AABB, 2'b00, 32'h0);
      vecs[6]  = mk(1, 0, 32'h80, 32'h0, 2'b11, 0, 1, 1, 32'h8899AABB, 2'b00, 32'h0);
      vecs[7]  = mk(1, 1, 32'h0C, 32'h0, 2'b11, 0, 1, 1, 32'h8899AABB, 2'b00, 32'h0);
      vecs[8]  = mk(1, 0, 32'h0C, 32'h0, 2'b10, 0, 1, 1, 32'h8899AABB, 2'b00, 32'h0);
      vecs[9]  = mk(0, 0, 32'h0C, 32'h0, 2'b11, 0, 1, 1, 32'h8899AABB, 2'b00, 32'h0);
      vecs[10] = mk(0, 1, 32'h10, 32'h12345678, 2'b11, 0, 0, 2, 32'h8899AABB, 2'b11, 32'h12345678);
      vecs[11] = mk(0, 1, 32'h10, 32'hAAAAAAEF, 2'b00, 0, 0, 2, 32'h8899AABB, 2'b00, 32'h123456EF);
      vecs[12] = mk(1, 0, 32'h10, 32'h0, 2'b11, 0, 0, 3, 32'h123456EF, 2'b00, 32'h0);
      vecs[13] = mk(1, 0, 32'h13, 32'h0, 2'b00, 1, 0, 3, 32'h00000012, 2'b00, 32'h0);
      vecs[14] = mk(1, 0, 32'h10, 32'h0, 2'b01, 1, 0, 3, 32'h000056EF, 2'b00, 32'h0);
      vecs[15] = mk(1, 0, 32'h0C, 32'h0, 2'b01, 1, 0, 3, 32'hFFFFAABB, 2'b00, 32'h0);
      n_vecs = 16;

      // Reset state
      repeat (3) @(negedge i_clk);
      check("reset ready", 32'(o_ready), 32'd1);
      check("reset done/fault", {30'd0, o_done, o_fault}, 32'd0);
      check("reset rdata", o_rdata, 32'd0);
      check("reset mem addr", o_mem_addr, 32'd0);
      check("reset mem wdata", o_mem_wdata, 32'd0);
      check("reset mem ctl", {27'd0, o_mem_write, o_mem_read, o_mem_long, o_mem_sign}, 32'd0);
      i_rst = 1'b1;

      // Preload every word through word stores
      for (int i = 0; i < DEPTH; i++) begin
         word = (i == 3) ? 32'h8899AABB : $urandom;
         do_checked($sformatf("preload%0d", i), 1'b0, 1'b1, 32'(i * 4), word, 2'b11, 1'b0);
      end

      // Directed table
      for (int i = 0; i < n_vecs; i++) begin
         model(vecs[i].ld, vecs[i].st, vecs[i].addr, vecs[i].wdata, vecs[i].size, vecs[i].sign, e);
         run_req(vecs[i].ld, vecs[i].st, vecs[i].addr, vecs[i].wdata, vecs[i].size, vecs[i].sign, r);
         check($sformatf("vec%0d latency", i), 32'(r.lat), 32'(vecs[i].exp_lat));
         check($sformatf("vec%0d fault", i), 32'(r.flt), 32'(vecs[i].exp_fault));
         check($sformatf("vec%0d rdata", i), r.rdata, vecs[i].exp_rdata);
         check($sformatf("vec%0d strobes", i), 32'(r.nrd + r.nwr), 32'(e.nrd + e.nwr));
         if (vecs[i].exp_fault) check($sformatf("vec%0d no strobe", i), 32'(r.nrd + r.nwr), 32'd0);
         if (vecs[i].st && !vecs[i].ld && !vecs[i].exp_fault) begin
            check($sformatf("vec%0d long", i), 32'(r.wlong), 32'(vecs[i].exp_long));
            check($sformatf("vec%0d word", i), dmem[(vecs[i].addr >> 2) % DEPTH], vecs[i].exp_word);
         end
         if (vecs[i].ld && !vecs[i].exp_fault)
            check($sformatf("vec%0d read addr", i), r.rd_addr, vecs[i].addr >> 2);
      end

      // Random requests against the reference model
      for (int i = 0; i < 200; i++) begin
         int op;
         logic ld, st;
         logic [31:0] a;
         op = $urandom_range(0, 9);
         ld = (op == 0) || (op >= 2 && op <= 5);
         st = (op == 0) || (op >= 6);
         a  = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 143));
         do_checked($sformatf("rand%0d", i), ld, st, a, $urandom, 2'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)));
      end

      // Reset in the RD_WAIT cycle of an access that has not written yet
      w3_before = dmem[3];
      @(negedge i_clk);
      i_load = !RMW_EN; i_store = RMW_EN; i_addr = 32'h0F; i_wdata = 32'h77;
      i_size = 2'b00; i_sign = 1'b0; i_valid = 1'b1;
      @(posedge i_clk);
      #1 i_valid = 1'b0;
      @(negedge i_clk);
      check("rst seq read strobe", 32'(o_mem_read), 32'd1);
      @(negedge i_clk);
      i_rst = 1'b0;
      #1;
      check("rst seq ready", 32'(o_ready), 32'd1);
      check("rst seq strobes", {30'd0, o_mem_write, o_mem_read}, 32'd0);
      bad = 0;
      for (int n = 0; n < 6; n++) begin
         @(negedge i_clk);
         if (n == 2) i_rst = 1'b1;
         if (o_done || o_mem_write) bad++;
      end
      check("rst seq no done/write", 32'(bad), 32'd0);
      check("rst seq word3", dmem[3], w3_before);
      check("rst seq rdata cleared", o_rdata, 32'd0);
      ref_rdata = '0;

      // Unit must be usable again after the aborted access
      do_checked("post reset load", 1'b1, 1'b0, 32'h0C, 32'h0, 2'b11, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
